// File: rtl/seq_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package seq_sub_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-look-ahead adder slice: s = a + b + cin, purely combinational.
module cla4_slice
    import seq_sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry expanded directly from generate/propagate terms.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/seq_sub16.sv
// Nibble-serial subtractor: diff = a - b, one 4-bit CLA slice per cycle, valid/ready on both sides.
module seq_sub16
    import seq_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NIBS  = WIDTH / NIB_W;
    localparam int unsigned CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [NIB_W-1:0] nib_b_inv;
    logic             nib_cin;
    logic [NIB_W-1:0] nib_s;
    logic             nib_cout;
    logic [WIDTH-1:0] diff_shift;

    // Operand registers shift right, so the low nibble is always the one in flight.
    assign nib_b_inv = ~b_q[NIB_W-1:0];
    assign nib_cin   = (cnt_q == '0) ? 1'b1 : carry_q;

    cla4_slice u_cla (
        .a    (a_q[NIB_W-1:0]),
        .b    (nib_b_inv),
        .cin  (nib_cin),
        .s    (nib_s),
        .cout (nib_cout)
    );

    assign diff_shift = (diff_q >> NIB_W) | (WIDTH'(nib_s) << (WIDTH - NIB_W));

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> NIB_W;
                b_d     = b_q >> NIB_W;
                diff_d  = diff_shift;
                carry_d = nib_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_NIB) begin
                    // Last nibble: a_q/b_q low nibbles now hold the original MSBs.
                    borrow_d = ~nib_cout;
                    ovf_d    = (a_q[NIB_W-1] ^ b_q[NIB_W-1]) & (nib_s[NIB_W-1] ^ a_q[NIB_W-1]);
                    zero_d   = (diff_shift == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/seq_sub16.md
SEQ_SUB16 -- requirements
Module: seq_sub16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; it SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 The block SHALL have port a, input, WIDTH bits: the minuend, unsigned or two's complement.
REQ-007 The block SHALL have port b, input, WIDTH bits: the subtrahend.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-011 The block SHALL have port borrow, output, 1 bit: unsigned a < b.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow.
REQ-013 The block SHALL have port zero, output, 1 bit: diff == 0.

Function
REQ-014 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready at a clock edge, which latches a and b into internal registers and moves the FSM to CALC.
REQ-016 In CALC the block SHALL process one 4-bit nibble per cycle, LSB nibble first, as a_nib + ~b_nib + cin, with cin = 1 for nibble 0 and the previous nibble's carry-out otherwise, using carry-look-ahead generate/propagate logic.
REQ-017 The nibble counter SHALL run 0 to WIDTH/4-1; after the edge that processes the last nibble, the FSM SHALL enter DONE.
REQ-018 out_valid SHALL rise exactly WIDTH/4 clock edges after the accepting edge (4 edges for WIDTH=16) and SHALL equal 1 only in DONE.
REQ-019 borrow SHALL equal the inverse of the final carry-out.
REQ-020 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-021 zero SHALL equal 1 when all bits of diff are 0.
REQ-022 While out_valid && !out_ready, diff, borrow, ovf and zero SHALL remain stable, and in_ready SHALL remain 0.
REQ-023 The edge with out_valid && out_ready SHALL return the FSM to IDLE; in_ready SHALL become 1 the following cycle, and there SHALL be no same-cycle result-and-accept overlap.
REQ-024 Changes on a/b while not in IDLE SHALL have no effect on the result.
REQ-025 in_valid asserted in CALC or DONE SHALL be ignored and not queued.

Reset
REQ-026 When rst is high at an edge, the block SHALL go to IDLE, clear the nibble counter, carry and operand/result registers, and set in_ready=1, out_valid=0, diff=0, borrow=0, ovf=0 and zero=0 (zero is registered, so it is not derived from diff during reset).
REQ-027 Reset in CALC or DONE SHALL discard the operation silently; rst SHALL take priority over any simultaneous handshake.

Structure
REQ-028 Shared package seq_sub_pkg SHALL hold the state enum (IDLE/CALC/DONE) and constant NIB_W=4.
REQ-029 The block SHALL instantiate one combinational sub-module, cla4_slice, with inputs a[3:0], b[3:0] and cin, and outputs s[3:0] and cout, with 4-bit carry-look-ahead internals; seq_sub16 SHALL feed it ~b.
REQ-030 The result SHALL be assembled by shifting each nibble sum into the diff register.

Verification
REQ-031 a=0x1234, b=0x0234 -> diff=0x1000, borrow=0, ovf=0, zero=0; out_valid exactly 4 edges after accept.
REQ-032 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0, zero=0.
REQ-033 a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1; and a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, ovf=1.
REQ-034 a=b=0xA5A5 -> diff=0x0000, zero=1, borrow=0; then hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0; new in_valid is ignored.
REQ-035 Assert rst for 1 cycle during CALC (after 2 nibbles) -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a new accept gives a correct result.
REQ-036 Run 1000 back-to-back random transactions with random out_ready -> every result equals (a-b) mod 2^16 with correct flags, and there is no lost or duplicated result.
